// File: rtl/bp_fe_queue_roll_if.sv
//==============================================================================
// Module      : bp_fe_queue_roll_if
// Description : FE->BE queue handshake bundle (enqueue, issue, commit, rollback)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bp_fe_queue_roll_if #(
  parameter int width_p = 128
);
  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               yumi_i;
  logic               clr_i;
  logic               deq_i;
  logic               roll_i;

  modport slave (
    input  data_i, v_i, yumi_i, clr_i, deq_i, roll_i,
    output ready_o, data_o, v_o
  );

  modport master (
    output data_i, v_i, yumi_i, clr_i, deq_i, roll_i,
    input  ready_o, data_o, v_o
  );
endinterface

`default_nettype wire

// File: rtl/bp_fe_queue_roll.sv
//==============================================================================
// Module      : bp_fe_queue_roll
// Description : FE queue with speculative issue pointer, commit pointer and
//               rollback to the oldest uncommitted entry.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bp_fe_queue_roll #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  wire logic          clk_i,
  input  wire logic          reset_n_i,
  bp_fe_queue_roll_if.slave  q_if
);

  localparam int IDX_W = $clog2(els_p);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] c_els = PTR_W'(els_p);
  localparam logic [PTR_W-1:0] c_one = PTR_W'(1);

  logic [PTR_W-1:0]   r_wptr, r_rptr, r_cptr;
  logic [PTR_W-1:0]   w_wptr_nxt, w_rptr_nxt, w_cptr_nxt;
  logic [width_p-1:0] r_mem [els_p];
  logic               w_full, w_empty, w_issued_any;
  logic               w_enq, w_deq, w_yumi;

  // Full is measured against the commit pointer: issued entries still hold slots.
  assign w_full       = (r_wptr - r_cptr) == c_els;
  assign w_empty      = (r_rptr == r_wptr);
  assign w_issued_any = (r_cptr != r_rptr);

  assign q_if.ready_o = ~w_full;
  assign q_if.v_o     = ~w_empty;
  assign q_if.data_o  = r_mem[r_rptr[IDX_W-1:0]];

  assign w_enq  = q_if.v_i & ~w_full & ~q_if.clr_i;
  assign w_deq  = q_if.deq_i & ~q_if.clr_i & w_issued_any;
  assign w_yumi = q_if.yumi_i & ~q_if.roll_i & ~q_if.clr_i & ~w_empty;

  always_comb begin
    w_wptr_nxt = r_wptr;
    w_cptr_nxt = r_cptr;
    w_rptr_nxt = r_rptr;
    if (q_if.clr_i) begin
      w_cptr_nxt = r_wptr;
      w_rptr_nxt = r_wptr;
    end else begin
      if (w_enq)
        w_wptr_nxt = r_wptr + c_one;
      if (w_deq)
        w_cptr_nxt = r_cptr + c_one;
      // Rollback lands on the post-commit position so a same-cycle deq is honoured.
      if (q_if.roll_i)
        w_rptr_nxt = w_cptr_nxt;
      else if (w_yumi)
        w_rptr_nxt = r_rptr + c_one;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_cptr <= w_cptr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq)
      r_mem[r_wptr[IDX_W-1:0]] <= q_if.data_i;
  end

  a_deq_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (q_if.deq_i && !q_if.clr_i) |-> w_issued_any);

  a_yumi_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (q_if.yumi_i && !q_if.roll_i && !q_if.clr_i) |-> !w_empty);

endmodule

`default_nettype wire

// File: tb/tb_bp_fe_queue_roll.sv
//==============================================================================
// Module      : tb_bp_fe_queue_roll
// Description : Self-checking bench for bp_fe_queue_roll against a queue model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bp_fe_queue_roll;

  localparam int ELS = 8;
  localparam int W   = 128;

  logic clk_i;
  logic reset_n_i;
  int   checks;
  int   errors;

  // Model: all uncommitted entries oldest first; the first n_iss are issued.
  logic [W-1:0] mq[$];
  int           n_iss;

  bp_fe_queue_roll_if #(.width_p(W)) q_if ();

  bp_fe_queue_roll #(.els_p(ELS), .width_p(W)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .q_if      (q_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic m_ready();
    return mq.size() != ELS;
  endfunction

  function automatic logic m_valid();
    return n_iss < mq.size();
  endfunction

  task automatic model_clear();
    mq.delete();
    n_iss = 0;
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                      input logic dq, input logic rl, input logic cl);
    logic v_pre, acc;
    q_if.v_i    = v;
    q_if.data_i = d;
    q_if.yumi_i = y;
    q_if.deq_i  = dq;
    q_if.roll_i = rl;
    q_if.clr_i  = cl;
    v_pre = m_valid();
    acc   = v && m_ready() && !cl;
    @(posedge clk_i);
    #1;
    if (cl) begin
      model_clear();
    end else begin
      if (acc) mq.push_back(d);
      if (dq && n_iss > 0) begin
        void'(mq.pop_front());
        n_iss--;
      end
      if (rl) n_iss = 0;
      else if (y && v_pre) n_iss++;
    end
    q_if.v_i    = 1'b0;
    q_if.yumi_i = 1'b0;
    q_if.deq_i  = 1'b0;
    q_if.roll_i = 1'b0;
    q_if.clr_i  = 1'b0;
  endtask

  task automatic enq(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    reset_n_i   = 1'b0;
    q_if.v_i    = 1'b0;
    q_if.data_i = '0;
    q_if.yumi_i = 1'b0;
    q_if.deq_i  = 1'b0;
    q_if.roll_i = 1'b0;
    q_if.clr_i  = 1'b0;
    model_clear();
    #2;
    checks++;
    if (q_if.v_o !== 1'b0 || q_if.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state v_o=%b ready_o=%b want v_o=0 ready_o=1", q_if.v_o, q_if.ready_o);
    end
    // Enqueue is presented across reset release so the first edge takes it.
    d = rnd_data();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q_if.v_o !== 1'b1 || q_if.data_o !== d) begin
      errors++;
      $display("FAIL first_enq v_o=%b data_o=%h want v_o=1 data_o=%h", q_if.v_o, q_if.data_o, d);
    end
    flush();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= ELS; i++) begin
      enq(W'(i));
      checks++;
      if (q_if.ready_o !== (i != ELS)) begin
        errors++;
        $display("FAIL fill_ready i=%0d ready_o=%b want %b", i, q_if.ready_o, (i != ELS));
      end
    end
    enq(W'(9));
    checks++;
    if (q_if.ready_o !== 1'b0 || q_if.v_o !== 1'b1 || q_if.data_o !== W'(1) || mq.size() != ELS) begin
      errors++;
      $display("FAIL fill_ninth ready_o=%b v_o=%b data_o=%h want 0 1 %h", q_if.ready_o, q_if.v_o,
               q_if.data_o, W'(1));
    end
    flush();
  endtask

  task automatic test_issue_roll();
    logic [W-1:0] dv[3];
    for (int i = 0; i < 3; i++) begin
      dv[i] = rnd_data();
      enq(dv[i]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q_if.data_o !== dv[i]) begin
        errors++;
        $display("FAIL issue_order i=%0d data_o=%h want %h", i, q_if.data_o, dv[i]);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (q_if.v_o !== 1'b1 || q_if.data_o !== dv[0]) begin
      errors++;
      $display("FAIL roll_rewind v_o=%b data_o=%h want 1 %h", q_if.v_o, q_if.data_o, dv[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_if.v_o !== 1'b1 || q_if.data_o !== dv[i]) begin
        errors++;
        $display("FAIL reissue i=%0d v_o=%b data_o=%h want 1 %h", i, q_if.v_o, q_if.data_o, dv[i]);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (q_if.v_o !== 1'b0) begin
      errors++;
      $display("FAIL reissue_empty v_o=%b want 0", q_if.v_o);
    end
    flush();
  endtask

  task automatic test_deq_roll();
    logic [W-1:0] dv[3];
    int n_acc;
    for (int i = 0; i < 3; i++) begin
      dv[i] = rnd_data();
      enq(dv[i]);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (q_if.v_o !== 1'b1 || q_if.data_o !== dv[1]) begin
      errors++;
      $display("FAIL deq_roll_data v_o=%b data_o=%h want 1 %h", q_if.v_o, q_if.data_o, dv[1]);
    end
    // Two entries held, so exactly ELS-2 more accepts before full.
    n_acc = 0;
    for (int i = 0; i < ELS + 2; i++) begin
      if (q_if.ready_o !== 1'b1) break;
      enq(rnd_data());
      n_acc++;
    end
    checks++;
    if (n_acc != ELS - 2) begin
      errors++;
      $display("FAIL deq_roll_space accepts=%0d want %0d", n_acc, ELS - 2);
    end
    flush();
  endtask

  task automatic test_clr();
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) enq(rnd_data());
    step(1'b1, W'(32'hD), 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (q_if.v_o !== 1'b0 || q_if.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_state v_o=%b ready_o=%b want 0 1", q_if.v_o, q_if.ready_o);
    end
    e = W'(32'hE);
    enq(e);
    checks++;
    if (q_if.v_o !== 1'b1 || q_if.data_o !== e) begin
      errors++;
      $display("FAIL clr_drop_enq v_o=%b data_o=%h want 1 %h", q_if.v_o, q_if.data_o, e);
    end
    flush();
  endtask

  task automatic test_wrap();
    // Deterministic rounds push the pointers through several wrap-bit toggles.
    for (int r = 0; r < 20; r++) begin
      int n = 1 + (r % 3);
      logic [W-1:0] dv[3];
      for (int i = 0; i < n; i++) begin
        dv[i] = rnd_data();
        enq(dv[i]);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (q_if.v_o !== 1'b1 || q_if.data_o !== dv[i] || q_if.ready_o !== m_ready()) begin
          errors++;
          $display("FAIL wrap_round r=%0d i=%0d v_o=%b data_o=%h ready_o=%b want 1 %h %b", r, i,
                   q_if.v_o, q_if.data_o, q_if.ready_o, dv[i], m_ready());
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (q_if.v_o !== 1'b0 || q_if.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end v_o=%b ready_o=%b want 0 1", q_if.v_o, q_if.ready_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic v, y, dq, rl, cl;
      v  = ($urandom_range(0, 3) != 0);
      y  = m_valid() && ($urandom_range(0, 2) != 0);
      dq = (n_iss > 0) && ($urandom_range(0, 2) == 0);
      rl = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 63) == 0);
      step(v, rnd_data(), y, dq, rl, cl);
      checks++;
      if (q_if.ready_o !== m_ready() || q_if.v_o !== m_valid() ||
          (m_valid() && q_if.data_o !== mq[n_iss])) begin
        errors++;
        $display("FAIL random c=%0d ready_o=%b v_o=%b data_o=%h want %b %b %h", c, q_if.ready_o,
                 q_if.v_o, q_if.data_o, m_ready(), m_valid(), m_valid() ? mq[n_iss] : '0);
      end
    end
    flush();
  endtask

  task automatic test_async_reset();
    logic [W-1:0] f;
    for (int i = 0; i < 5; i++) enq(rnd_data());
    checks++;
    if (q_if.v_o !== 1'b1 || q_if.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset v_o=%b ready_o=%b want 1 1", q_if.v_o, q_if.ready_o);
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (q_if.v_o !== 1'b0 || q_if.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset v_o=%b ready_o=%b want 0 1", q_if.v_o, q_if.ready_o);
    end
    model_clear();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    f = rnd_data();
    enq(f);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q_if.v_o !== 1'b0 || n_iss != 1 || mq.size() != 1 || mq[0] !== f) begin
      errors++;
      $display("FAIL post_reset_entries v_o=%b want 0", q_if.v_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_issue_roll();
    test_deq_roll();
    test_clr();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_fe_queue_roll.md
BP_FE_QUEUE_ROLL -- requirements
Module: bp_fe_queue_roll

Interface
REQ-001 SHALL have parameter els_p, default 8, queue depth in entries (power of two, >=2).
REQ-002 SHALL have parameter width_p, default 128, entry width in bits (FE queue packet width).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port data_i, input, width_p, FE packet to enqueue.
REQ-006 SHALL have port v_i, input, 1, enqueue valid from FE.
REQ-007 SHALL have port ready_o, output, 1, space available (valid/ready; enqueue when v_i & ready_o).
REQ-008 SHALL have port data_o, output, width_p, entry at speculative read pointer.
REQ-009 SHALL have port v_o, output, 1, data_o holds an unissued entry.
REQ-010 SHALL have port yumi_i, input, 1, BE consumes data_o (legal only when v_o).
REQ-011 SHALL have port clr_i, input, 1, discard all entries (BE flush).
REQ-012 SHALL have port deq_i, input, 1, commit oldest issued entry (frees its slot).
REQ-013 SHALL have port roll_i, input, 1, rewind read pointer to oldest uncommitted entry.

Function
REQ-014 SHALL keep three (log2(els_p)+1)-bit pointers: wptr (write), rptr (speculative read), cptr (commit); MSB is the wrap bit, the remaining bits index storage.
REQ-015 SHALL hold invariant cptr <= rptr <= wptr (modulo-2*els_p distance); entries cptr..rptr-1 issued-uncommitted, rptr..wptr-1 unissued.
REQ-016 SHALL drive ready_o = (wptr - cptr) != els_p (full counted against cptr, not rptr); ready_o SHALL NOT depend on clr_i, roll_i, deq_i or yumi_i.
REQ-017 SHALL drive v_o = (rptr != wptr), from registered state only.
REQ-018 SHALL drive data_o combinationally from storage[rptr index]; data_o undefined when v_o=0.
REQ-019 SHALL write data_i to storage[wptr index] and increment wptr when v_i & ready_o & ~clr_i; enqueued entry visible on v_o/data_o the next cycle (1-cycle latency, no bypass).
REQ-020 SHALL increment cptr when deq_i & ~clr_i; deq_i with cptr == rptr is illegal (simulation assertion; pointer unchanged).
REQ-021 SHALL increment rptr when yumi_i & ~roll_i & ~clr_i; yumi_i with v_o=0 is illegal (assertion; pointer unchanged).
REQ-022 SHALL set rptr to the next-cycle cptr value (cptr, or cptr+1 if deq_i same cycle) when roll_i & ~clr_i; same-cycle yumi_i ignored.
REQ-023 SHALL, on clr_i, set rptr and cptr to current wptr and drop any same-cycle enqueue (wptr unchanged, storage not written); clr_i overrides roll_i, deq_i, yumi_i.
REQ-024 SHALL handle pointer wrap by natural modulo-2*els_p overflow; full/empty distinguished by wrap bit.
REQ-025 SHALL allow simultaneous enqueue and deq_i when full: ready_o stays 0 that cycle (ready_o from registered state), slot freed next cycle.
REQ-026 SHALL NOT add combinational paths from any input to ready_o or v_o.

Reset
REQ-027 SHALL, while reset_n_i=0, asynchronously force wptr=rptr=cptr=0, giving v_o=0, ready_o=1.
REQ-028 SHALL NOT reset storage; after reset deassertion first enqueue accepted in the first active clock edge.
REQ-029 SHALL, on reset mid-operation, discard all entries; no entry enqueued before reset appears on v_o afterwards.

Verification
REQ-030 SHALL cover fill: els_p=8, enqueue 8 packets 0x1..0x8 without deq -> ready_o=0 after 8th accept; 9th v_i not accepted; v_o=1, data_o=0x1.
REQ-031 SHALL cover issue+roll: enqueue A,B,C; yumi A,B; roll_i -> next cycle data_o=A, v_o=1; yumi ordering A,B,C repeats.
REQ-032 SHALL cover deq+roll same cycle: A,B,C enqueued, A,B issued, deq_i & roll_i together -> next cycle data_o=B, one slot freed (wptr-cptr=2).
REQ-033 SHALL cover clr with enqueue: 3 entries present, clr_i with v_i=1, data_i=0xD -> next cycle v_o=0, ready_o=1, 0xD never issued.
REQ-034 SHALL cover wrap: 20 enqueue/yumi/deq rounds at depth 8 with 0-3 in flight -> in-order data, no loss, ready_o/v_o correct across wrap-bit toggles.
REQ-035 SHALL cover async reset: assert reset_n_i mid-cycle with 5 entries -> v_o=0, ready_o=1 immediately, before next clock edge.
